// File: rtl/fft_pkg.sv
// Shared constants and tracker state encoding for the FFT magnitude/peak stage.
package fft_pkg;
    localparam int NBINS_DEF = 128;
    localparam int DW_DEF    = 8;
    localparam int IDXW_DEF  = 7;

    localparam int RE_MSB = 15;
    localparam int RE_LSB = 8;
    localparam int IM_MSB = 7;
    localparam int IM_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_ACC    = 3'b010,
        ST_REPORT = 3'b100
    } state_e;
endpackage

// File: rtl/fft_mag_peak_if.sv
// Bin input stream plus power stream and peak report outputs of fft_mag_peak.
interface fft_mag_peak_if
    import fft_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int IDXW = IDXW_DEF
);
    logic            in_valid;
    logic [2*DW-1:0] in_data;
    logic            mag_valid;
    logic [2*DW-1:0] mag_out;
    logic [IDXW-1:0] mag_idx;
    logic            peak_valid;
    logic [IDXW-1:0] peak_idx;
    logic [2*DW-1:0] peak_mag;
    logic            busy;

    modport master (
        output in_valid, in_data,
        input  mag_valid, mag_out, mag_idx, peak_valid, peak_idx, peak_mag, busy
    );

    modport slave (
        input  in_valid, in_data,
        output mag_valid, mag_out, mag_idx, peak_valid, peak_idx, peak_mag, busy
    );
endinterface

// File: rtl/fft_mag_sq.sv
// Two-stage re^2 + im^2 pipeline; bin index and valid travel alongside the data.
module fft_mag_sq
    import fft_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int IDXW = IDXW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [2*DW-1:0] in_data,
    input  logic [IDXW-1:0] in_idx,
    output logic            s1_valid,
    output logic            mag_valid,
    output logic [2*DW-1:0] mag_out,
    output logic [IDXW-1:0] mag_idx
);
    // Squares are kept at 2*DW-1 bits: (-128)^2 = 16384 needs the extra bit.
    logic signed [DW-1:0]   re_s, im_s;
    logic signed [2*DW-2:0] re_x_s, im_x_s, re_p_s, im_p_s;
    logic [2*DW-2:0]        re_sq_r, im_sq_r;
    logic [IDXW-1:0]        idx1_r, idx2_r;
    logic                   v1_r, v2_r;
    logic [2*DW-1:0]        mag_r;

    // Sign-extend the components and square them.
    always_comb begin
        re_s   = in_data[RE_MSB:RE_LSB];
        im_s   = in_data[IM_MSB:IM_LSB];
        re_x_s = {{(DW-1){re_s[DW-1]}}, re_s};
        im_x_s = {{(DW-1){im_s[DW-1]}}, im_s};
        re_p_s = re_x_s * re_x_s;
        im_p_s = im_x_s * im_x_s;
    end

    // Stage 1: register the squares and the sideband.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r    <= 1'b0;
            re_sq_r <= {(2*DW-1){1'b0}};
            im_sq_r <= {(2*DW-1){1'b0}};
            idx1_r  <= {IDXW{1'b0}};
        end else begin
            v1_r <= in_valid;
            if (in_valid) begin
                re_sq_r <= re_p_s;
                im_sq_r <= im_p_s;
                idx1_r  <= in_idx;
            end
        end
    end

    // Stage 2: sum of squares; cannot overflow 2*DW bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r   <= 1'b0;
            mag_r  <= {(2*DW){1'b0}};
            idx2_r <= {IDXW{1'b0}};
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                mag_r  <= {1'b0, re_sq_r} + {1'b0, im_sq_r};
                idx2_r <= idx1_r;
            end
        end
    end

    assign s1_valid  = v1_r;
    assign mag_valid = v2_r;
    assign mag_out   = mag_r;
    assign mag_idx   = idx2_r;
endmodule

// File: rtl/fft_mag_peak.sv
// Per-bin power stream and per-frame peak tracker behind the 128-point FFT.
// Optional macro FFT_PEAK_HALF_SPECTRUM_EN restricts the peak search to bins 1..NBINS/2-1.
module fft_mag_peak
    import fft_pkg::*;
#(
    parameter int NBINS = NBINS_DEF,
    parameter int DW    = DW_DEF,
    parameter int IDXW  = IDXW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fft_mag_peak_if.slave bus
);
    logic [IDXW-1:0] bin_cnt_r, bin_cnt_next_s;
    logic            s1_valid_s, mag_valid_s, in_range_s, report_s, in_flight_s, busy_r, busy_next_s;
    logic [2*DW-1:0] mag_s, cand_mag_r, cand_mag_next_s, peak_mag_r;
    logic [IDXW-1:0] mag_idx_s, cand_idx_r, cand_idx_next_s, peak_idx_r;
    state_e          state_r, state_next_s;

`ifdef FFT_PEAK_HALF_SPECTRUM_EN
    localparam logic [IDXW-1:0] FIRST_IDX = IDXW'(1);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NBINS/2 - 1);
    assign in_range_s = (mag_idx_s != {IDXW{1'b0}}) && (mag_idx_s <= LAST_IDX);
`else
    localparam logic [IDXW-1:0] FIRST_IDX = {IDXW{1'b0}};
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NBINS - 1);
    assign in_range_s = 1'b1;
`endif

    fft_mag_sq #(.DW(DW), .IDXW(IDXW)) u_mag_sq (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_data   (bus.in_data),
        .in_idx    (bin_cnt_r),
        .s1_valid  (s1_valid_s),
        .mag_valid (mag_valid_s),
        .mag_out   (mag_s),
        .mag_idx   (mag_idx_s)
    );

    // Bin counter next value and the busy look-ahead.
    always_comb begin
        bin_cnt_next_s = bin_cnt_r;
        if (bus.in_valid) begin
            bin_cnt_next_s = bin_cnt_r + IDXW'(1);
        end else begin
            bin_cnt_next_s = bin_cnt_r;
        end
        busy_next_s = (bin_cnt_next_s != {IDXW{1'b0}}) || bus.in_valid || s1_valid_s;
        in_flight_s = bus.in_valid || (bin_cnt_r != {IDXW{1'b0}}) || s1_valid_s || mag_valid_s;
    end

    // Candidate update; the report uses this value so the last bin is included.
    always_comb begin
        cand_mag_next_s = cand_mag_r;
        cand_idx_next_s = cand_idx_r;
        report_s        = mag_valid_s && (mag_idx_s == LAST_IDX);
        if (mag_valid_s && in_range_s && ((mag_idx_s == FIRST_IDX) || (mag_s > cand_mag_r))) begin
            cand_mag_next_s = mag_s;
            cand_idx_next_s = mag_idx_s;
        end else begin
            cand_mag_next_s = cand_mag_r;
            cand_idx_next_s = cand_idx_r;
        end
    end

    // Tracker FSM next state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (report_s)          state_next_s = ST_REPORT;
                else if (bus.in_valid) state_next_s = ST_ACC;
                else                   state_next_s = ST_IDLE;
            end
            ST_ACC, ST_REPORT: begin
                if (report_s)         state_next_s = ST_REPORT;
                else if (in_flight_s) state_next_s = ST_ACC;
                else                  state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, counter, candidate and held peak registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            bin_cnt_r  <= {IDXW{1'b0}};
            busy_r     <= 1'b0;
            cand_mag_r <= {(2*DW){1'b0}};
            cand_idx_r <= {IDXW{1'b0}};
            peak_mag_r <= {(2*DW){1'b0}};
            peak_idx_r <= {IDXW{1'b0}};
        end else begin
            state_r    <= state_next_s;
            bin_cnt_r  <= bin_cnt_next_s;
            busy_r     <= busy_next_s;
            cand_mag_r <= cand_mag_next_s;
            cand_idx_r <= cand_idx_next_s;
            if (report_s) begin
                peak_mag_r <= cand_mag_next_s;
                peak_idx_r <= cand_idx_next_s;
            end
        end
    end

    assign bus.mag_valid  = mag_valid_s;
    assign bus.mag_out    = mag_s;
    assign bus.mag_idx    = mag_idx_s;
    assign bus.peak_valid = state_r[2];
    assign bus.peak_idx   = peak_idx_r;
    assign bus.peak_mag   = peak_mag_r;
    assign bus.busy       = busy_r;
endmodule
